// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide
// sharing one 33-bit adder/subtractor. Optional macro MULDIV_EARLY_OUT_EN enables early-out.
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rst_pipe,
  input  logic        cmd_muldiv_ex,
  input  logic [2:0]  muldiv_code_ex,
  input  logic [31:0] rs1_sel,
  input  logic [31:0] rs2_sel,
  input  logic        jmp_purge_ma,
  input  logic        stall_ext,
  output logic        muldiv_stall,
  output logic        muldiv_done,
  output logic [31:0] muldiv_result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  code_q;
  logic [32:0] hi_q;    // multiply accumulator / divide partial remainder
  logic [31:0] lo_q;    // multiplier / quotient (dividend shifts out as quotient shifts in)
  logic [31:0] opb_q;   // multiplicand / divisor
  logic        neg_quo_q, neg_rem_q, div0_q, ovf_q;
  logic        done_q;
  logic [31:0] result_q;

  logic        accept, is_div, sgn_a, sgn_b;
  logic [31:0] op_a, op_b;
  logic        div0_in, ovf_in, neg_quo_in, neg_rem_in, early;
  logic [31:0] early_res;

  assign accept = (state_q == IDLE) & cmd_muldiv_ex & ~jmp_purge_ma & ~stall_ext;
  assign is_div = muldiv_code_ex[2];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (muldiv_code_ex)
      3'd1, 3'd4, 3'd6: begin sgn_a = 1'b1; sgn_b = 1'b1; end
      3'd2:             sgn_a = 1'b1;
      default:          ;
    endcase
  end

  assign op_a       = (sgn_a & rs1_sel[31]) ? (~rs1_sel + 32'd1) : rs1_sel;
  assign op_b       = (sgn_b & rs2_sel[31]) ? (~rs2_sel + 32'd1) : rs2_sel;
  assign neg_quo_in = (sgn_a & rs1_sel[31]) ^ (sgn_b & rs2_sel[31]);
  assign neg_rem_in = is_div & sgn_a & rs1_sel[31];
  assign div0_in    = is_div & (rs2_sel == 32'd0);
  assign ovf_in     = is_div & ~muldiv_code_ex[0] & ~div0_in &
                      (rs1_sel == 32'h8000_0000) & (rs2_sel == 32'hFFFF_FFFF);

  always_comb begin
    early_res = 32'd0;
    if (div0_in)     early_res = muldiv_code_ex[1] ? rs1_sel : 32'hFFFF_FFFF;
    else if (ovf_in) early_res = muldiv_code_ex[1] ? 32'd0 : 32'h8000_0000;
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic mul0_in;
  assign mul0_in = ~is_div & ((rs1_sel == 32'd0) | (rs2_sel == 32'd0));
  assign early   = div0_in | ovf_in | mul0_in;
`else
  assign early   = 1'b0;
`endif

  // Shared adder: add for multiply, subtract (carry-out = no borrow) for divide.
  logic        sub_op;
  logic [32:0] add_a, add_b, mul_sum;
  logic [33:0] add_sum;
  logic [32:0] hi_d;
  logic [31:0] lo_d;

  assign sub_op  = code_q[2];
  assign add_a   = sub_op ? {hi_q[31:0], lo_q[31]} : hi_q;
  assign add_b   = sub_op ? ~{1'b0, opb_q} : {1'b0, opb_q};
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {33'd0, sub_op};
  assign mul_sum = lo_q[0] ? add_sum[32:0] : hi_q;

  always_comb begin
    hi_d = {1'b0, mul_sum[32:1]};
    lo_d = {mul_sum[0], lo_q[31:1]};
    if (sub_op) begin
      if (add_sum[33]) begin
        hi_d = {1'b0, add_sum[31:0]};
        lo_d = {lo_q[30:0], 1'b1};
      end else begin
        hi_d = {1'b0, hi_q[30:0], lo_q[31]};
        lo_d = {lo_q[30:0], 1'b0};
      end
    end
  end

  // Sign fix-up and result select. A divide by zero leaves |rs1| in the remainder,
  // so the signed fix-up already yields rs1 there; only the quotient is overridden.
  logic [63:0] product, prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_res;

  always_comb begin
    product  = {hi_q[31:0], lo_q};
    prod_fix = neg_quo_q ? (~product + 64'd1) : product;
    quo_fix  = neg_quo_q ? (~lo_q + 32'd1) : lo_q;
    rem_fix  = neg_rem_q ? (~hi_q[31:0] + 32'd1) : hi_q[31:0];
    fix_res  = 32'd0;
    case (code_q)
      3'd0:             fix_res = prod_fix[31:0];
      3'd1, 3'd2, 3'd3: fix_res = prod_fix[63:32];
      3'd4, 3'd5:       fix_res = div0_q ? 32'hFFFF_FFFF : (ovf_q ? 32'h8000_0000 : quo_fix);
      default:          fix_res = ovf_q ? 32'd0 : rem_fix;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      code_q    <= 3'd0;
      hi_q      <= 33'd0;
      lo_q      <= 32'd0;
      opb_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
    end else if (rst_pipe) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          code_q    <= muldiv_code_ex;
          hi_q      <= 33'd0;
          lo_q      <= op_a;
          opb_q     <= op_b;
          neg_quo_q <= neg_quo_in;
          neg_rem_q <= neg_rem_in;
          div0_q    <= div0_in;
          ovf_q     <= ovf_in;
          if (early) begin
            state_q  <= DONE;
            cnt_q    <= 5'd0;
            done_q   <= 1'b1;
            result_q <= early_res;
          end else begin
            state_q  <= CALC;
            cnt_q    <= 5'd31;
          end
        end
        CALC: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (cnt_q == 5'd0) state_q <= FIX;
          else               cnt_q   <= cnt_q - 5'd1;
        end
        FIX: begin
          result_q <= fix_res;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: if (!stall_ext) begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign muldiv_stall  = accept | (state_q == CALC) | (state_q == FIX);
  assign muldiv_done   = done_q;
  assign muldiv_result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: result values, latency and stall profile,
// plus rst_pipe abort, stall_ext hold in DONE and squashed-command sequences.
module tb_muldiv_seq;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, rst_pipe, cmd_muldiv_ex, jmp_purge_ma, stall_ext;
  logic [2:0]  muldiv_code_ex;
  logic [31:0] rs1_sel, rs2_sel;
  logic        muldiv_stall, muldiv_done;
  logic [31:0] muldiv_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rst_pipe       (rst_pipe),
    .cmd_muldiv_ex  (cmd_muldiv_ex),
    .muldiv_code_ex (muldiv_code_ex),
    .rs1_sel        (rs1_sel),
    .rs2_sel        (rs2_sel),
    .jmp_purge_ma   (jmp_purge_ma),
    .stall_ext      (stall_ext),
    .muldiv_stall   (muldiv_stall),
    .muldiv_done    (muldiv_done),
    .muldiv_result  (muldiv_result)
  );

  typedef struct {
    logic [2:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;  // eligible for early-out
  } vec_t;

  vec_t  vecs[20];
  string op_name[8] = '{"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge (T0), follow it to DONE, optionally hold DONE with stall_ext.
  task automatic run_op(input string name, input logic [2:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit special,
                        input int hold);
    int lat, stalls, exp_lat;
    logic [31:0] res;
    exp_lat = (EARLY && special) ? 1 : 34;
    @(negedge clk);
    cmd_muldiv_ex  = 1'b1;
    muldiv_code_ex = code;
    rs1_sel        = a;
    rs2_sel        = b;
    #1;
    stalls = muldiv_stall ? 1 : 0;
    lat    = 0;
    while (!muldiv_done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (muldiv_stall) stalls++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " stall cycles"}, 32'(stalls), 32'(exp_lat));
    check({name, " result"}, muldiv_result, exp);
    res = muldiv_result;
    if (hold > 0) begin
      stall_ext = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({name, " hold done"}, {31'd0, muldiv_done}, 32'd1);
        check({name, " hold result"}, muldiv_result, res);
        check({name, " hold stall"}, {31'd0, muldiv_stall}, 32'd0);
      end
      stall_ext = 1'b0;
    end
    cmd_muldiv_ex = 1'b0;
    @(negedge clk);
    check({name, " done drops"}, {31'd0, muldiv_done}, 32'd0);
    check({name, " idle stall"}, {31'd0, muldiv_stall}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        1'b0};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         1'b0};
    vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1'b1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1};
    vecs[12] = '{3'd0, 32'd0,          32'd12345,     32'd0,         1'b1};
    vecs[13] = '{3'd5, 32'hFFFF_FFFF,  32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[14] = '{3'd7, 32'hDEAD_BEEF,  32'd0,         32'hDEAD_BEEF, 1'b1};
    vecs[15] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1'b1};
    vecs[16] = '{3'd4, 32'hFFFF_FFF8,  32'hFFFF_FFFD, 32'd2,         1'b0};
    vecs[17] = '{3'd6, 32'hFFFF_FFF8,  32'hFFFF_FFFD, 32'hFFFF_FFFE, 1'b0};
    vecs[18] = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         1'b0};
    vecs[19] = '{3'd0, 32'h1234_5678,  32'h10,        32'h2345_6780, 1'b0};

    rst_n = 1'b0; rst_pipe = 1'b0; cmd_muldiv_ex = 1'b0; jmp_purge_ma = 1'b0;
    stall_ext = 1'b0; muldiv_code_ex = 3'd0; rs1_sel = 32'd0; rs2_sel = 32'd0;
    repeat (2) @(negedge clk);
    check("reset stall", {31'd0, muldiv_stall}, 32'd0);
    check("reset done", {31'd0, muldiv_done}, 32'd0);
    check("reset result", muldiv_result, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++)
      run_op($sformatf("%s#%0d", op_name[vecs[i].code], i), vecs[i].code, vecs[i].a,
             vecs[i].b, vecs[i].exp, vecs[i].special, 0);

    // Result register holds its value back in IDLE.
    @(negedge clk);
    check("result held in idle", muldiv_result, 32'h2345_6780);

    // Abort mid-CALC with rst_pipe, then a fresh DIVU 9/3.
    @(negedge clk);
    cmd_muldiv_ex = 1'b1; muldiv_code_ex = 3'd5; rs1_sel = 32'd1000; rs2_sel = 32'd3;
    repeat (10) @(negedge clk);
    check("mid-calc stall", {31'd0, muldiv_stall}, 32'd1);
    rst_pipe = 1'b1;
    cmd_muldiv_ex = 1'b0;
    @(negedge clk);
    rst_pipe = 1'b0;
    check("flush stall", {31'd0, muldiv_stall}, 32'd0);
    check("flush done", {31'd0, muldiv_done}, 32'd0);
    check("flush result", muldiv_result, 32'd0);
    run_op("DIVU after flush", 3'd5, 32'd9, 32'd3, 32'd3, 1'b0, 0);

    // stall_ext held three cycles in DONE.
    run_op("MULHU hold", 3'd3, 32'h0001_0000, 32'h0003_0000, 32'd3, 1'b0, 3);

    // Squashed command is never accepted.
    @(negedge clk);
    cmd_muldiv_ex = 1'b1; jmp_purge_ma = 1'b1; muldiv_code_ex = 3'd0;
    rs1_sel = 32'd0; rs2_sel = 32'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("purge stall", {31'd0, muldiv_stall}, 32'd0);
      @(negedge clk);
      check("purge done", {31'd0, muldiv_done}, 32'd0);
    end
    cmd_muldiv_ex = 1'b0; jmp_purge_ma = 1'b0;

    // A blocked command (stall_ext) is not accepted either.
    stall_ext = 1'b1; cmd_muldiv_ex = 1'b1; muldiv_code_ex = 3'd5;
    rs1_sel = 32'd9; rs2_sel = 32'd0;
    #1;
    check("stall_ext blocks accept", {31'd0, muldiv_stall}, 32'd0);
    @(negedge clk);
    check("stall_ext no done", {31'd0, muldiv_done}, 32'd0);
    stall_ext = 1'b0; cmd_muldiv_ex = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
